// File: rtl/disparity_pkg.sv
// disparity_pkg
//   Shared constants, types and helpers for the disparity writer.
//   Frame geometry, the FIFO word layout, the write FSM encoding, and the
//   disparity-to-grey conversion.
//   Configuration macro: DISP_WRITER_SCALE_EN
//     defined   -> grey byte = disparity shifted to the top of the byte
//     undefined -> grey byte = zero-extended raw disparity
package disparity_pkg;

    localparam int F_WIDTH    = 320;  // frame width in pixels (even)
    localparam int F_HEIGHT   = 240;  // frame height in lines
    localparam int DISP_W     = 6;    // disparity width
    localparam int ADDR_W     = 16;   // word address width
    localparam int FIFO_DEPTH = 16;   // packed-word FIFO entries (power of 2)
    localparam int COORD_W    = 10;   // pixel coordinate width

    // Address of the word holding the bottom-right pixel pair.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(F_WIDTH * F_HEIGHT / 2 - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        logic              last;
    } fifo_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wr_state_t;

    // Disparity index to 8-bit grey level.
    function automatic logic [7:0] pix(input logic [DISP_W-1:0] d);
`ifdef DISP_WRITER_SCALE_EN
        return 8'(d) << (8 - DISP_W);
`else
        return 8'(d);
`endif
    endfunction

    // Word address of a pixel: linear pixel index at full width, halved.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        logic [ADDR_W:0] lin;
        lin = (ADDR_W+1)'(y) * (ADDR_W+1)'(F_WIDTH) + (ADDR_W+1)'(x);
        return ADDR_W'(lin >> 1);
    endfunction

endpackage

// File: rtl/disparity_word_fifo.sv
// disparity_word_fifo
//   Synchronous FIFO of fifo_word_t. A push on a full FIFO is accepted only
//   if a pop happens in the same cycle; otherwise it is ignored (the caller
//   flags the drop). Pops on an empty FIFO are ignored.
//   Ports:
//     clk, reset_n    clock, asynchronous active-low reset
//     push, push_word write strobe and entry
//     pop, pop_word   read strobe and current head (valid when !empty)
//     full, empty     occupancy flags
module disparity_word_fifo
    import disparity_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  fifo_word_t push_word,
    input  logic       pop,
    output fifo_word_t pop_word,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_word_t         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign pop_word = mem[rd_ptr];

    // NOTE: storage has no reset; occupancy is tracked by the pointers and
    // count, so stale contents are never observed and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/disparity_writer.sv
// disparity_writer
//   Converts the per-pixel disparity stream to 8-bit grey, packs horizontal
//   pixel pairs into 16-bit words, queues them and writes them to the frame
//   buffer over a req/ack handshake.
//   Configuration macro: DISP_WRITER_SCALE_EN (see disparity_pkg::pix).
//   Ports:
//     clk, reset_n          clock, asynchronous active-low reset
//     disparity_val         input qualifier for disparity/in_x/in_y
//     disparity             best-match disparity index
//     in_x, in_y            pixel coordinate of the disparity
//     mem_req               write request, held until mem_ack
//     mem_addr, mem_wdata   word address; {odd-X byte, even-X byte}
//     mem_ack               write accepted (only meaningful with mem_req)
//     frame_done            one-cycle pulse after the last word is acked
//     overflow              sticky: a word was dropped on a full FIFO
module disparity_writer
    import disparity_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disparity_val,
    input  logic [DISP_W-1:0] disparity,
    input  logic [9:0]        in_x,
    input  logic [9:0]        in_y,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              frame_done,
    output logic              overflow
);

    // ---------------------------------------------------------------
    // Pack stage
    // ---------------------------------------------------------------
    logic [7:0]        in_byte;
    logic [ADDR_W-1:0] in_addr;
    logic              pend_valid;
    logic [7:0]        pend_byte;
    logic [ADDR_W-1:0] pend_addr;
    logic              push;
    fifo_word_t        push_word;

    assign in_byte = pix(disparity);
    assign in_addr = word_addr(in_x, in_y);

    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (disparity_val) begin
            if (!in_x[0]) begin
                // A new even pixel evicts an unpaired one as a half word.
                if (pend_valid) begin
                    push           = 1'b1;
                    push_word.addr = pend_addr;
                    push_word.data = {8'h00, pend_byte};
                    push_word.last = (pend_addr == LAST_ADDR);
                end
            end else begin
                push           = 1'b1;
                push_word.addr = in_addr;
                push_word.data = {in_byte,
                                  (pend_valid && pend_addr == in_addr) ? pend_byte : 8'h00};
                push_word.last = (in_addr == LAST_ADDR);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            pend_addr  <= '0;
        end else if (disparity_val) begin
            if (!in_x[0]) begin
                pend_valid <= 1'b1;
                pend_byte  <= in_byte;
                pend_addr  <= in_addr;
            end else begin
                pend_valid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Word FIFO
    // ---------------------------------------------------------------
    logic       fifo_pop;
    fifo_word_t head;
    logic       fifo_full;
    logic       fifo_empty;

    disparity_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_word (push_word),
        .pop       (fifo_pop),
        .pop_word  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Write FSM
    // ---------------------------------------------------------------
    wr_state_t state;
    wr_state_t state_next;
    logic      cur_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = REQ;
            REQ:     if (mem_ack && fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mem_req decodes the state register directly so it falls with reset.
    always_comb begin
        mem_req  = (state == REQ);
        fifo_pop = !fifo_empty && ((state == IDLE) || (state == REQ && mem_ack));
    end

    // Output word registers load on every pop, keeping addr/data stable
    // for the whole request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cur_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (fifo_pop) begin
                mem_addr  <= head.addr;
                mem_wdata <= head.data;
                cur_last  <= head.last;
            end
            frame_done <= (state == REQ) && mem_ack && cur_last;
        end
    end

endmodule

// File: tb/tb_disparity_writer.sv
// tb_disparity_writer
//   Self-checking bench for disparity_writer. A transaction-level model turns
//   each pixel into the words the frame buffer should receive; a monitor
//   compares every acknowledged write and the frame_done pulse against it.
//   Honors DISP_WRITER_SCALE_EN the same way as the design.
module tb_disparity_writer;
    import disparity_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              disparity_val;
    logic [DISP_W-1:0] disparity;
    logic [9:0]        in_x;
    logic [9:0]        in_y;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic              frame_done;
    logic              overflow;

    disparity_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .disparity_val (disparity_val),
        .disparity     (disparity),
        .in_x          (in_x),
        .in_y          (in_y),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: pixel stream -> ordered list of frame-buffer words
    // ---------------------------------------------------------------
    typedef struct {
        int addr;
        int data;
        bit last;
    } exp_word_t;

    exp_word_t exp_q[$];
    bit        m_pend_valid = 0;
    int        m_pend_byte  = 0;
    int        m_pend_addr  = 0;
    int        accept_left  = -1;  // words the design can still hold; -1 = no limit

    function automatic int model_pix(input int d);
`ifdef DISP_WRITER_SCALE_EN
        return d * 4;
`else
        return d;
`endif
    endfunction

    function automatic void model_emit(input int addr, input int data);
        exp_word_t w;
        if (accept_left == 0) return;
        if (accept_left > 0) accept_left--;
        w.addr = addr;
        w.data = data;
        w.last = (addr == F_WIDTH * F_HEIGHT / 2 - 1);
        exp_q.push_back(w);
    endfunction

    function automatic void model_pixel(input int x, input int y, input int d);
        int b;
        int a;
        b = model_pix(d);
        a = (y * F_WIDTH + x) / 2;
        if (x % 2 == 0) begin
            if (m_pend_valid) model_emit(m_pend_addr, m_pend_byte);
            m_pend_valid = 1;
            m_pend_byte  = b;
            m_pend_addr  = a;
        end else begin
            model_emit(a, b * 256 + ((m_pend_valid && m_pend_addr == a) ? m_pend_byte : 0));
            m_pend_valid = 0;
        end
    endfunction

    // ---------------------------------------------------------------
    // Acknowledge driver: 0 = low, 1 = high, 2 = random
    // ---------------------------------------------------------------
    int ack_mode = 0;

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b0;
            1:       mem_ack = 1'b1;
            default: mem_ack = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------------------------------------------------------
    // Monitor (mid-cycle sampling)
    // ---------------------------------------------------------------
    bit mon_en    = 0;
    bit done_exp  = 0;
    int done_seen = 0;
    int log_addr[$];
    int log_data[$];

    always @(negedge clk) begin : monitor
        exp_word_t w;
        if (reset_n && mon_en) begin
            check("frame_done", frame_done, done_exp);
            if (frame_done) done_seen++;
            done_exp = 0;
            if (mem_req && mem_ack) begin
                check("write_expected", exp_q.size() != 0, 1);
                log_addr.push_back(int'(mem_addr));
                log_data.push_back(int'(mem_wdata));
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                    done_exp = w.last;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (all called at posedge+1)
    // ---------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int y, input int d);
        disparity_val = 1'b1;
        in_x          = 10'(x);
        in_y          = 10'(y);
        disparity     = DISP_W'(d);
        model_pixel(x, y, d);
        @(posedge clk);
        #1;
        disparity_val = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mem_req) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_drained"}, n < 500, 1);
    endtask

`ifdef DISP_WRITER_SCALE_EN
    localparam int PAIR_DATA = 32'h2414;
    localparam int ORPH_D0   = 32'h000C;
    localparam int ORPH_D1   = 32'h041C;
`else
    localparam int PAIR_DATA = 32'h0905;
    localparam int ORPH_D0   = 32'h0003;
    localparam int ORPH_D1   = 32'h0107;
`endif

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int nlog;
        int req_seen;
        reset_n       = 1'b0;
        disparity_val = 1'b0;
        disparity     = '0;
        in_x          = '0;
        in_y          = '0;
        mem_ack       = 1'b0;

        // Reset state
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1;
        idle(2);

        // Pair write with idle latency
        ack_mode = 1;
        mem_ack  = 1'b1;
        send(4, 2, 5);
        idle(3);
        check("even_alone_no_req", mem_req, 0);
        send(5, 2, 9);                 // odd pixel was cycle 0; now in cycle 1
        @(negedge clk);
        check("lat_cycle1_req", mem_req, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_req", mem_req, 1);
        check("pair_addr", mem_addr, 322);
        check("pair_data", mem_wdata, PAIR_DATA);
        @(posedge clk);
        #1;
        wait_drain("pair");

        // Orphan even pixel flushed by the next even pixel
        nlog = log_addr.size();
        send(10, 0, 3);
        send(12, 0, 7);
        send(13, 0, 1);
        wait_drain("orphan");
        check("orphan_count", log_addr.size() - nlog, 2);
        if (log_addr.size() - nlog == 2) begin
            check("orphan_addr0", log_addr[nlog], 5);
            check("orphan_data0", log_data[nlog], ORPH_D0);
            check("orphan_addr1", log_addr[nlog+1], 6);
            check("orphan_data1", log_data[nlog+1], ORPH_D1);
        end

        // Back-to-back: three queued words drain in three consecutive cycles
        ack_mode = 0;
        mem_ack  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(20 + 2 * i, 1, 10 + i);
            send(21 + 2 * i, 1, 20 + i);
        end
        idle(2);
        ack_mode = 1;
        mem_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b_req_%0d", i), mem_req, i < 3);
        end
        @(posedge clk);
        #1;
        wait_drain("b2b");

        // Frame end
        done_seen = 0;
        send(318, 239, 33);
        send(319, 239, 44);
        idle(6);
        check("frame_done_pulses", done_seen, 1);
        check("frame_last_addr", log_addr[log_addr.size()-1], 38399);

        // Back-pressure: one word in the output register plus 16 in the FIFO survive
        ack_mode    = 0;
        mem_ack     = 1'b0;
        accept_left = 1 + FIFO_DEPTH;
        nlog        = log_addr.size();
        for (int i = 0; i < 40; i++) begin
            int x;
            int y;
            x = 2 * int'($urandom_range(0, 158));
            y = int'($urandom_range(0, 238));
            send(x, y, int'($urandom_range(0, 63)));
            send(x + 1, y, int'($urandom_range(0, 63)));
        end
        idle(2);
        check("bp_overflow_set", overflow, 1);
        check("bp_req_held", mem_req, 1);
        ack_mode = 1;
        wait_drain("bp");
        check("bp_words_written", log_addr.size() - nlog, 1 + FIFO_DEPTH);
        check("bp_overflow_sticky", overflow, 1);
        accept_left = -1;

        // Randomized traffic with random acknowledges
        ack_mode = 2;
        for (int i = 0; i < 200; i++) begin
            int kind;
            int x;
            int y;
            kind = int'($urandom_range(0, 7));
            x    = 2 * int'($urandom_range(0, 159));
            y    = int'($urandom_range(0, F_HEIGHT - 1));
            if (kind == 6) begin
                send(x, y, int'($urandom_range(0, 63)));
            end else if (kind == 7) begin
                send(x + 1, y, int'($urandom_range(0, 63)));
            end else begin
                send(x, y, int'($urandom_range(0, 63)));
                send(x + 1, y, int'($urandom_range(0, 63)));
            end
            idle(int'($urandom_range(0, 3)));
        end
        ack_mode = 1;
        wait_drain("random");

        // Reset in the middle of a request
        ack_mode = 0;
        mem_ack  = 1'b0;
        send(50, 3, 11);
        send(51, 3, 12);
        send(60, 3, 13);               // left pending
        idle(2);
        check("rst_mid_req_before", mem_req, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        mon_en  = 0;
        #1;
        check("rst_mid_req_async", mem_req, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_overflow", overflow, 0);
        exp_q.delete();
        m_pend_valid = 0;
        done_exp     = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mon_en   = 1;
        ack_mode = 1;
        req_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_req) req_seen++;
        end
        check("rst_no_stale_req", req_seen, 0);
        @(posedge clk);
        #1;
        send(61, 3, 2);                // stale pending must not pair with this
        wait_drain("post_reset");
        check("model_empty_at_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
